id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB operand forwarding and load-use detection.
// Define ID_EX_BUBBLE_CNT_EN to add a 32-bit bubble_cnt output counting cycles with valid_e=0.
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [WIDTH-1:0] pc_d,
    input  logic [WIDTH-1:0] rd1_d,
    input  logic [WIDTH-1:0] rd2_d,
    input  logic [WIDTH-1:0] imm_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic [2:0]       alu_ctrl_d,
    input  logic             sral_d,
    input  logic             alusrc_d,
    input  logic             regwrite_d,
    input  logic             memwrite_d,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic [1:0]       resultsrc_d,
    input  logic [WIDTH-1:0] alu_result_m,
    input  logic [WIDTH-1:0] result_w,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    output logic [WIDTH-1:0] srca_e,
    output logic [WIDTH-1:0] srcb_e,
    output logic [2:0]       alu_ctrl_e,
    output logic             sral_e,
    output logic [WIDTH-1:0] write_data_e,
    output logic [WIDTH-1:0] pc_e,
    output logic [WIDTH-1:0] imm_e,
    output logic [4:0]       rd_e,
    output logic             regwrite_e,
    output logic             memwrite_e,
    output logic             branch_e,
    output logic             jump_e,
    output logic             valid_e,
    output logic [1:0]       resultsrc_e,
    output logic             lw_stall
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]      bubble_cnt
`endif
);
    logic [WIDTH-1:0] rd1_e, rd2_e;
    logic [4:0]       rs1_e, rs2_e;
    logic             alusrc_e;
    logic [1:0]       forward_a, forward_b;

    // A flushed bubble zeroes every field, so rs1_e/rs2_e=x0 cannot trigger forwarding.
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            pc_e        <= '0;
            rd1_e       <= '0;
            rd2_e       <= '0;
            imm_e       <= '0;
            rs1_e       <= '0;
            rs2_e       <= '0;
            rd_e        <= '0;
            alu_ctrl_e  <= '0;
            sral_e      <= 1'b0;
            alusrc_e    <= 1'b0;
            regwrite_e  <= 1'b0;
            memwrite_e  <= 1'b0;
            branch_e    <= 1'b0;
            jump_e      <= 1'b0;
            resultsrc_e <= '0;
            valid_e     <= 1'b0;
        end else if (!stall_e) begin
            pc_e        <= pc_d;
            rd1_e       <= rd1_d;
            rd2_e       <= rd2_d;
            imm_e       <= imm_d;
            rs1_e       <= rs1_d;
            rs2_e       <= rs2_d;
            rd_e        <= rd_d;
            alu_ctrl_e  <= alu_ctrl_d;
            sral_e      <= sral_d;
            alusrc_e    <= alusrc_d;
            regwrite_e  <= regwrite_d;
            memwrite_e  <= memwrite_d;
            branch_e    <= branch_d;
            jump_e      <= jump_d;
            resultsrc_e <= resultsrc_d;
            valid_e     <= 1'b1;
        end
    end

    always_comb begin
        forward_a    = (regwrite_m && rd_m != 5'd0 && rd_m == rs1_e) ? 2'b10 :
                       (regwrite_w && rd_w != 5'd0 && rd_w == rs1_e) ? 2'b01 : 2'b00;
        forward_b    = (regwrite_m && rd_m != 5'd0 && rd_m == rs2_e) ? 2'b10 :
                       (regwrite_w && rd_w != 5'd0 && rd_w == rs2_e) ? 2'b01 : 2'b00;
        srca_e       = forward_a == 2'b10 ? alu_result_m : forward_a == 2'b01 ? result_w : rd1_e;
        write_data_e = forward_b == 2'b10 ? alu_result_m : forward_b == 2'b01 ? result_w : rd2_e;
        srcb_e       = alusrc_e ? imm_e : write_data_e;
        lw_stall     = valid_e && resultsrc_e == 2'b01 && rd_e != 5'd0 &&
                       (rd_e == rs1_d || rd_e == rs2_d);
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            bubble_cnt <= '0;
        else if (!valid_e)
            bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenario tasks with hand-computed expectations for id_ex_stage.
module tb_id_ex_stage;
    localparam int WIDTH = 32;
    logic clk = 1'b0;
    logic reset, stall_e, flush_e;
    logic [WIDTH-1:0] pc_d, rd1_d, rd2_d, imm_d, alu_result_m, result_w;
    logic [4:0] rs1_d, rs2_d, rd_d, rd_m, rd_w;
    logic [2:0] alu_ctrl_d;
    logic sral_d, alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d, regwrite_m, regwrite_w;
    logic [1:0] resultsrc_d;
    logic [WIDTH-1:0] srca_e, srcb_e, write_data_e, pc_e, imm_e;
    logic [2:0] alu_ctrl_e;
    logic [4:0] rd_e;
    logic [1:0] resultsrc_e;
    logic sral_e, regwrite_e, memwrite_e, branch_e, jump_e, valid_e, lw_stall;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .pc_d(pc_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .alu_ctrl_d(alu_ctrl_d), .sral_d(sral_d), .alusrc_d(alusrc_d),
        .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .branch_d(branch_d),
        .jump_d(jump_d), .resultsrc_d(resultsrc_d),
        .alu_result_m(alu_result_m), .result_w(result_w),
        .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .srca_e(srca_e), .srcb_e(srcb_e), .alu_ctrl_e(alu_ctrl_e), .sral_e(sral_e),
        .write_data_e(write_data_e), .pc_e(pc_e), .imm_e(imm_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .branch_e(branch_e),
        .jump_e(jump_e), .valid_e(valid_e), .resultsrc_e(resultsrc_e),
        .lw_stall(lw_stall)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_e = 0; flush_e = 0;
        pc_d = 0; rd1_d = 0; rd2_d = 0; imm_d = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0; alu_ctrl_d = 0;
        sral_d = 0; alusrc_d = 0; regwrite_d = 0; memwrite_d = 0;
        branch_d = 0; jump_d = 0; resultsrc_d = 0;
        alu_result_m = 0; result_w = 0; rd_m = 0; rd_w = 0;
        regwrite_m = 0; regwrite_w = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; stall_e = 1; flush_e = 0;
        pc_d = 32'h44; rd1_d = 32'h9; rd2_d = 32'h8; rd_d = 5'd7; regwrite_d = 1;
        tick();
        tick();
        checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_e); end
        checks++; if (pc_e !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_e); end
        checks++; if (srca_e !== 32'h0 || srcb_e !== 32'h0) begin errors++; $display("FAIL reset_src: got %h/%h expected 0/0", srca_e, srcb_e); end
        checks++; if (lw_stall !== 1'b0 || regwrite_e !== 1'b0 || rd_e !== 5'd0) begin errors++; $display("FAIL reset_ctrl: got lw=%b rw=%b rd=%0d expected 0/0/0", lw_stall, regwrite_e, rd_e); end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_pass_through();
        idle_inputs();
        pc_d = 32'h100; rd1_d = 5; rd2_d = 7; imm_d = 32'h99; rs1_d = 1; rs2_d = 2; rd_d = 9;
        alu_ctrl_d = 3'd5; sral_d = 1; regwrite_d = 1; memwrite_d = 1; branch_d = 1; jump_d = 1; resultsrc_d = 2'b10;
        #1;
        checks++; if (pc_e !== 32'h0) begin errors++; $display("FAIL latency_before_edge: got %h expected 0", pc_e); end
        tick();
        checks++; if (srca_e !== 32'd5 || srcb_e !== 32'd7 || valid_e !== 1'b1) begin errors++; $display("FAIL pass_through: got a=%h b=%h v=%b expected 5/7/1", srca_e, srcb_e, valid_e); end
        checks++; if ({pc_e, imm_e, rd_e, alu_ctrl_e, sral_e} !== {32'h100, 32'h99, 5'd9, 3'd5, 1'b1}) begin errors++; $display("FAIL pass_fields: got pc=%h imm=%h rd=%0d alu=%0d sral=%b expected 100/99/9/5/1", pc_e, imm_e, rd_e, alu_ctrl_e, sral_e); end
        checks++; if ({regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e} !== 6'b111110) begin errors++; $display("FAIL pass_ctrl: got %b expected 111110", {regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e}); end
        alusrc_d = 1;
        tick();
        checks++; if (srcb_e !== 32'h99 || write_data_e !== 32'd7) begin errors++; $display("FAIL alusrc_imm: got b=%h wd=%h expected 99/7", srcb_e, write_data_e); end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        rs1_d = 3; rs2_d = 0; rd1_d = 32'h11; rd2_d = 0;
        tick();
        rd_m = 3; rd_w = 3; regwrite_m = 1; regwrite_w = 1; alu_result_m = 32'hA; result_w = 32'hB;
        #1;
        checks++; if (srca_e !== 32'hA) begin errors++; $display("FAIL fwd_priority: got %h expected a", srca_e); end
        regwrite_m = 0;
        #1;
        checks++; if (srca_e !== 32'hB) begin errors++; $display("FAIL fwd_wb: got %h expected b", srca_e); end
        regwrite_w = 0;
        #1;
        checks++; if (srca_e !== 32'h11) begin errors++; $display("FAIL fwd_none: got %h expected 11", srca_e); end
        rd_m = 0; regwrite_m = 1; alu_result_m = 32'hFF; rd_w = 0; regwrite_w = 1; result_w = 32'hEE;
        #1;
        checks++; if (write_data_e !== 32'h0 || srcb_e !== 32'h0) begin errors++; $display("FAIL fwd_x0: got wd=%h b=%h expected 0/0", write_data_e, srcb_e); end
        idle_inputs();
        rs2_d = 6; rd2_d = 32'h22;
        tick();
        rd_w = 6; regwrite_w = 1; result_w = 32'h66;
        #1;
        checks++; if (write_data_e !== 32'h66 || srcb_e !== 32'h66) begin errors++; $display("FAIL fwd_b_wb: got wd=%h b=%h expected 66/66", write_data_e, srcb_e); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        rd_d = 4; resultsrc_d = 2'b01; regwrite_d = 1;
        tick();
        rs1_d = 4; rs2_d = 5;
        #1;
        checks++; if (lw_stall !== 1'b1) begin errors++; $display("FAIL load_use_rs1: got %b expected 1", lw_stall); end
        rs1_d = 5; rs2_d = 4;
        #1;
        checks++; if (lw_stall !== 1'b1) begin errors++; $display("FAIL load_use_rs2: got %b expected 1", lw_stall); end
        rs2_d = 6;
        #1;
        checks++; if (lw_stall !== 1'b0) begin errors++; $display("FAIL load_use_nomatch: got %b expected 0", lw_stall); end
        idle_inputs();
        rd_d = 0; resultsrc_d = 2'b01;
        tick();
        rs1_d = 0;
        #1;
        checks++; if (lw_stall !== 1'b0) begin errors++; $display("FAIL load_use_x0: got %b expected 0", lw_stall); end
        idle_inputs();
        rd_d = 4; resultsrc_d = 2'b00;
        tick();
        rs1_d = 4;
        #1;
        checks++; if (lw_stall !== 1'b0) begin errors++; $display("FAIL load_use_not_load: got %b expected 0", lw_stall); end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        pc_d = 32'h100; rd_d = 8; regwrite_d = 1; alu_ctrl_d = 3'd2;
        tick();
        stall_e = 1; pc_d = 32'h200; rd_d = 9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_e !== 32'h100 || rd_e !== 5'd8 || valid_e !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got pc=%h rd=%0d v=%b expected 100/8/1", i, pc_e, rd_e, valid_e); end
        end
        flush_e = 1;
        tick();
        checks++; if (valid_e !== 1'b0 || regwrite_e !== 1'b0 || rd_e !== 5'd0 || alu_ctrl_e !== 3'd0) begin errors++; $display("FAIL stall_flush: got v=%b rw=%b rd=%0d alu=%0d expected 0/0/0/0", valid_e, regwrite_e, rd_e, alu_ctrl_e); end
        stall_e = 0; flush_e = 0;
        tick();
        checks++; if (pc_e !== 32'h200 || valid_e !== 1'b1) begin errors++; $display("FAIL after_flush: got pc=%h v=%b expected 200/1", pc_e, valid_e); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        pc_d = 32'h300; regwrite_d = 1; rd1_d = 32'h5;
        tick();
        reset = 1; flush_e = 0; stall_e = 1;
        tick();
        checks++; if (pc_e !== 32'h0 || valid_e !== 1'b0 || regwrite_e !== 1'b0 || srca_e !== 32'h0) begin errors++; $display("FAIL reset_mid: got pc=%h v=%b rw=%b a=%h expected 0/0/0/0", pc_e, valid_e, regwrite_e, srca_e); end
        reset = 0; stall_e = 0;
    endtask

`ifdef ID_EX_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        logic [31:0] base;
        idle_inputs();
        tick();
        base = bubble_cnt;
        flush_e = 1;
        tick(); tick(); tick();
        flush_e = 0;
        tick();
        checks++; if (bubble_cnt - base !== 32'd3) begin errors++; $display("FAIL bubble_cnt_flush3: got %0d expected 3", bubble_cnt - base); end
        reset = 1;
        tick();
        checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL bubble_cnt_reset: got %0d expected 0", bubble_cnt); end
        reset = 0;
    endtask
`endif

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_pass_through();
        test_forwarding();
        test_load_use();
        test_stall_flush();
        test_reset_mid();
`ifdef ID_EX_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
